vga_timing_gen: RTL and testbench

//  Generates VGA raster timing (640x480@60 Hz by default) from a single pixel-rate clock.

---
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with optional clock-enable divider
// Every output is registered from the next-state x/y, so HS/VS/blank always match the x/y on the bus.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CE_DIV   = 1
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       HS,
    output logic       VS,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       blank,
    output logic       pix_ce,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CE_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_q, blank_d;
    logic             pix_ce_q, pix_ce_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             adv;

    always_comb begin
        adv           = (div_q == DIV_MAX);
        div_d         = adv ? '0 : div_q + DIV_W'(1);
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (adv) begin
            if (x_q == H_MAX) begin
                x_d          = '0;
                line_start_d = 1'b1;
                if (y_q == V_MAX) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        // Decode from the next position so the registered flags line up with x/y.
        hs_d     = (x_d >= HS_START && x_d < HS_END) ? HS_POL : ~HS_POL;
        vs_d     = (y_d >= VS_START && y_d < VS_END) ? VS_POL : ~VS_POL;
        blank_d  = (x_d >= H_ACT) || (y_d >= V_ACT);
        pix_ce_d = adv;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            blank_q       <= 1'b0;
            pix_ce_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            pix_ce_q      <= pix_ce_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign HS          = hs_q;
    assign VS          = vs_q;
    assign x           = x_q;
    assign y           = y_q;
    assign blank       = blank_q;
    assign pix_ce      = pix_ce_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen
// Default 640x480 instance gets directed checks; a tiny CE_DIV=2 instance is scoreboarded every clock.
module tb_vga_timing_gen;

    localparam int S_HT = 15;
    localparam int S_VT = 12;

    logic       clk;
    logic       rst, rst2;
    logic       hs, vs, blank, pce, ls, fs;
    logic [9:0] x, y;
    logic       hs2, vs2, blank2, pce2, ls2, fs2;
    logic [9:0] x2, y2;

    int n_cmp = 0;
    int n_bad = 0;
    int c2 = 0;
    int rises = 0;
    logic vs_prev = 1'b1;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic hs, vs, blank, pce, ls, fs;
    } exp_t;
    exp_t sb_q[$];

    vga_timing_gen u_dut (
        .CLK(clk), .RST(rst), .HS(hs), .VS(vs), .x(x), .y(y), .blank(blank),
        .pix_ce(pce), .line_start(ls), .frame_start(fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .CE_DIV(2)
    ) u_small (
        .CLK(clk), .RST(rst2), .HS(hs2), .VS(vs2), .x(x2), .y(y2), .blank(blank2),
        .pix_ce(pce2), .line_start(ls2), .frame_start(fs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Clock c after reset release: pixel k = c/2, raster position from k alone.
    function automatic exp_t model(input int c);
        exp_t e;
        int k, xx, yy;
        k       = c / 2;
        xx      = k % S_HT;
        yy      = (k / S_HT) % S_VT;
        e.x     = 10'(xx);
        e.y     = 10'(yy);
        e.pce   = (c > 0) && (c % 2 == 0);
        e.hs    = !(xx >= 10 && xx < 13);
        e.vs    = !(yy >= 8 && yy < 10);
        e.blank = (xx >= 8) || (yy >= 6);
        e.ls    = e.pce && (xx == 0);
        e.fs    = e.ls && (yy == 0);
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst2) c2 = 0;
        else      c2 = c2 + 1;
        sb_q.push_back(model(c2));
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_x", 32'(x2), 32'(e.x));
            chk("sb_y", 32'(y2), 32'(e.y));
            chk("sb_hs", 32'(hs2), 32'(e.hs));
            chk("sb_vs", 32'(vs2), 32'(e.vs));
            chk("sb_blank", 32'(blank2), 32'(e.blank));
            chk("sb_pix_ce", 32'(pce2), 32'(e.pce));
            chk("sb_line_start", 32'(ls2), 32'(e.ls));
            chk("sb_frame_start", 32'(fs2), 32'(e.fs));
        end
        if (!vs_prev && vs2) rises++;
        vs_prev = vs2;
    end

    initial begin
        rst  = 1'b0;
        rst2 = 1'b0;
        #1;
        rst  = 1'b1;
        rst2 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_hs", 32'(hs), 1);
        chk("rst_vs", 32'(vs), 1);
        chk("rst_blank", 32'(blank), 0);
        chk("rst_pix_ce", 32'(pce), 0);
        chk("rst_line_start", 32'(ls), 0);
        chk("rst_frame_start", 32'(fs), 0);

        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("x_after_5", 32'(x), 5);
        chk("pix_ce_run", 32'(pce), 1);
        chk("no_start_at_release", 32'(ls), 0);

        repeat (634) @(negedge clk);
        chk("x639", 32'(x), 639);
        chk("blank_x639", 32'(blank), 0);
        @(negedge clk);
        chk("blank_x640", 32'(blank), 1);
        repeat (15) @(negedge clk);
        chk("x655", 32'(x), 655);
        chk("hs_x655", 32'(hs), 1);
        @(negedge clk);
        chk("hs_x656", 32'(hs), 0);
        repeat (95) @(negedge clk);
        chk("x751", 32'(x), 751);
        chk("hs_x751", 32'(hs), 0);
        @(negedge clk);
        chk("hs_x752", 32'(hs), 1);
        repeat (47) @(negedge clk);
        chk("x799", 32'(x), 799);
        chk("y_line0", 32'(y), 0);
        @(negedge clk);
        chk("wrap_x", 32'(x), 0);
        chk("wrap_y", 32'(y), 1);
        chk("wrap_line_start", 32'(ls), 1);
        chk("wrap_frame_start", 32'(fs), 0);
        @(negedge clk);
        chk("post_line_start", 32'(ls), 0);
        chk("post_frame_start", 32'(fs), 0);

        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_x", 32'(x), 0);
        chk("async_y", 32'(y), 0);
        chk("async_hs", 32'(hs), 1);
        chk("async_pix_ce", 32'(pce), 0);

        // Small instance: two full frames, then a mid-frame asynchronous reset.
        @(negedge clk);
        #2 rst2 = 1'b0;
        rises = 0;
        repeat (720) @(negedge clk);
        chk("frame2_x", 32'(x2), 0);
        chk("frame2_y", 32'(y2), 0);
        chk("frame2_start", 32'(fs2), 1);
        chk("vs_rises", 32'(rises), 2);
        repeat (110) @(negedge clk);
        chk("mid_x", 32'(x2), 10);
        chk("mid_y", 32'(y2), 3);
        #2 rst2 = 1'b1;
        #1;
        chk("async2_x", 32'(x2), 0);
        chk("async2_y", 32'(y2), 0);
        chk("async2_hs", 32'(hs2), 1);
        chk("async2_vs", 32'(vs2), 1);
        chk("async2_blank", 32'(blank2), 0);
        chk("async2_pix_ce", 32'(pce2), 0);
        @(negedge clk);
        #2 rst2 = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
